// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUX = 1'b1;

  localparam int unsigned CNT_W = 3;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);
  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_gnt;
  logic              r0_rvalid;
  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_gnt;
  logic              r1_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  mem_rdata,
    output r0_gnt, r0_rvalid, r1_gnt, r1_rvalid,
    output rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output mem_rdata,
    input  r0_gnt, r0_rvalid, r1_gnt, r1_rvalid,
    input  rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker; the pointer names the favoured ID.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       winner_o,
  output logic       any_req_o
);
  always_comb begin
    any_req_o = |req_i;
    winner_o  = REQ_CPU;
    if (req_i == 2'b11) begin
      winner_o = ptr_i;
    end else if (req_i[REQ_AUX]) begin
      winner_o = REQ_AUX;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin, one-access-at-a-time arbiter sharing a single-port memory
// between the CPU datapath port (r0) and a loader/debug port (r1).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  mem_port_arbiter_if.slave bus
);
  state_e            state_q;
  logic              ptr_q;
  logic              win_q;
  cnt_t              cnt_q;
  logic              r0_gnt_q, r1_gnt_q;
  logic              r0_rvalid_q, r1_rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic winner, any_req, deliver;

  rr_arb2 u_rr (
    .req_i    ({bus.r1_req, bus.r0_req}),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .any_req_o(any_req)
  );

  // Read data is captured one edge early so rvalid/rdata are registered yet
  // appear in the cycle the counter reads 1 (or the first WAIT cycle when MEM_LAT=1).
  always_comb begin
    deliver = ((state_q == ACCESS) && !mem_we_q && (MEM_LAT == 1)) ||
              ((state_q == WAIT) && (cnt_q == cnt_t'(2)));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= REQ_CPU;
      win_q       <= REQ_CPU;
      cnt_q       <= '0;
      r0_gnt_q    <= 1'b0;
      r1_gnt_q    <= 1'b0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      r0_gnt_q    <= 1'b0;
      r1_gnt_q    <= 1'b0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      mem_en_q    <= 1'b0;
      if (deliver) begin
        r0_rvalid_q <= (win_q == REQ_CPU);
        r1_rvalid_q <= (win_q == REQ_AUX);
        rdata_q     <= bus.mem_rdata;
      end
      case (state_q)
        IDLE: begin
          if (any_req) begin
            win_q       <= winner;
            ptr_q       <= ~winner;
            r0_gnt_q    <= (winner == REQ_CPU);
            r1_gnt_q    <= (winner == REQ_AUX);
            mem_en_q    <= 1'b1;
            mem_we_q    <= winner ? bus.r1_we    : bus.r0_we;
            mem_addr_q  <= winner ? bus.r1_addr  : bus.r0_addr;
            mem_wdata_q <= winner ? bus.r1_wdata : bus.r0_wdata;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we_q <= 1'b0;
          if (mem_we_q) begin
            state_q <= IDLE;
          end else begin
            cnt_q   <= cnt_t'(MEM_LAT);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - cnt_t'(1);
          if (cnt_q <= cnt_t'(1)) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.r0_gnt    = r0_gnt_q;
  assign bus.r1_gnt    = r1_gnt_q;
  assign bus.r0_rvalid = r0_rvalid_q;
  assign bus.r1_rvalid = r1_rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter with MEM_LAT=2 against a one-stage synchronous RAM model:
// directed table, hand sequences for contention and mid-read reset, then random traffic.
module tb_mem_port_arbiter;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 64;
  localparam int unsigned LAT = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  typedef struct {
    logic          r0_req;
    logic          r0_we;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r1_req;
    logic          r1_we;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          exp_win;
  } vec_t;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  logic [DW-1:0] env_mem [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_rdata;
  logic          m_ptr;
  logic          mon_on = 1'b0;
  vec_t          tbl [9];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Environment RAM: captures on the mem_en edge, data readable one cycle later.
  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_we) env_mem[bus.mem_addr[10:3]] <= bus.mem_wdata;
      else            bus.mem_rdata <= env_mem[bus.mem_addr[10:3]];
    end else begin
      bus.mem_rdata <= {$urandom, $urandom};
    end
  end

  always @(negedge clock) begin
    if (mon_on) begin
      chk("gnt_exclusive", 64'(bus.r0_gnt & bus.r1_gnt), 64'd0);
      chk("rvalid_exclusive", 64'(bus.r0_rvalid & bus.r1_rvalid), 64'd0);
    end
  end

  task automatic drive(input vec_t v);
    bus.r0_req = v.r0_req; bus.r0_we = v.r0_we; bus.r0_addr = v.r0_addr; bus.r0_wdata = v.r0_wdata;
    bus.r1_req = v.r1_req; bus.r1_we = v.r1_we; bus.r1_addr = v.r1_addr; bus.r1_wdata = v.r1_wdata;
  endtask

  task automatic idle_inputs();
    vec_t v;
    v = '{1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0};
    drive(v);
  endtask

  task automatic wiggle();
    bus.r0_req = 1'($urandom); bus.r0_we = 1'($urandom);
    bus.r0_addr = $urandom; bus.r0_wdata = {$urandom, $urandom};
    bus.r1_req = 1'($urandom); bus.r1_we = 1'($urandom);
    bus.r1_addr = $urandom; bus.r1_wdata = {$urandom, $urandom};
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".r0_gnt"}, 64'(bus.r0_gnt), 64'd0);
    chk({tag, ".r1_gnt"}, 64'(bus.r1_gnt), 64'd0);
    chk({tag, ".r0_rvalid"}, 64'(bus.r0_rvalid), 64'd0);
    chk({tag, ".r1_rvalid"}, 64'(bus.r1_rvalid), 64'd0);
    chk({tag, ".rdata"}, bus.rdata, 64'd0);
    chk({tag, ".mem_en"}, 64'(bus.mem_en), 64'd0);
    chk({tag, ".mem_we"}, 64'(bus.mem_we), 64'd0);
    chk({tag, ".mem_addr"}, 64'(bus.mem_addr), 64'd0);
    chk({tag, ".mem_wdata"}, bus.mem_wdata, 64'd0);
    chk({tag, ".busy"}, 64'(bus.busy), 64'd0);
  endtask

  // Issue one request set from IDLE and follow it until IDLE again.
  task automatic run_access(input vec_t v, input string tag);
    logic          win, we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int unsigned   last;
    @(negedge clock);
    drive(v);
    @(posedge clock); #1;
    if (!(v.r0_req || v.r1_req)) begin
      chk({tag, ".noreq_busy"}, 64'(bus.busy), 64'd0);
      chk({tag, ".noreq_mem_en"}, 64'(bus.mem_en), 64'd0);
      chk({tag, ".noreq_gnt"}, 64'(bus.r0_gnt | bus.r1_gnt), 64'd0);
      return;
    end
    win = v.exp_win;
    we  = win ? v.r1_we    : v.r0_we;
    a   = win ? v.r1_addr  : v.r0_addr;
    wd  = win ? v.r1_wdata : v.r0_wdata;
    chk({tag, ".r0_gnt"}, 64'(bus.r0_gnt), 64'(!win));
    chk({tag, ".r1_gnt"}, 64'(bus.r1_gnt), 64'(win));
    chk({tag, ".mem_en"}, 64'(bus.mem_en), 64'd1);
    chk({tag, ".mem_we"}, 64'(bus.mem_we), 64'(we));
    chk({tag, ".mem_addr"}, 64'(bus.mem_addr), 64'(a));
    chk({tag, ".mem_wdata"}, bus.mem_wdata, wd);
    chk({tag, ".busy_acc"}, 64'(bus.busy), 64'd1);
    if (we) ref_mem[a[10:3]] = wd;
    m_ptr = ~win;
    last = we ? 1 : LAT + 1;
    for (int unsigned k = 1; k <= last; k++) begin
      if (k >= 2) begin
        @(negedge clock);
        wiggle();
      end
      @(posedge clock); #1;
      if (!we && k == LAT) exp_rdata = ref_mem[a[10:3]];
      chk($sformatf("%s.r0_rvalid@%0d", tag, k), 64'(bus.r0_rvalid), 64'(!we && k == LAT && !win));
      chk($sformatf("%s.r1_rvalid@%0d", tag, k), 64'(bus.r1_rvalid), 64'(!we && k == LAT && win));
      chk($sformatf("%s.rdata@%0d", tag, k), bus.rdata, exp_rdata);
      chk($sformatf("%s.busy@%0d", tag, k), 64'(bus.busy), 64'(k < last));
      chk($sformatf("%s.mem_en@%0d", tag, k), 64'(bus.mem_en), 64'd0);
      chk($sformatf("%s.gnt@%0d", tag, k), 64'(bus.r0_gnt | bus.r1_gnt), 64'd0);
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v.r0_req   = ($urandom_range(0, 3) != 0);
    v.r1_req   = ($urandom_range(0, 3) != 0);
    v.r0_we    = 1'($urandom);
    v.r1_we    = 1'($urandom);
    v.r0_addr  = {21'b0, 8'($urandom), 3'b0};
    v.r1_addr  = {21'b0, 8'($urandom), 3'b0};
    v.r0_wdata = {$urandom, $urandom};
    v.r1_wdata = {$urandom, $urandom};
    // Both requesting: pointer's favourite; otherwise whoever asked.
    v.exp_win  = (v.r0_req && v.r1_req) ? m_ptr : v.r1_req;
    return v;
  endfunction

  initial begin
    vec_t v;
    for (int i = 0; i < 256; i++) env_mem[i] = {$urandom, $urandom};
    env_mem[32] = 64'hDEADBEEF_00000001;
    for (int i = 0; i < 256; i++) ref_mem[i] = env_mem[i];
    idle_inputs();
    bus.mem_rdata = '0;

    repeat (3) @(posedge clock);
    #1;
    chk_all_zero("reset");
    mon_on = 1'b1;

    // Both hold write requests from reset: grants must alternate r0, r1, r0, r1.
    @(negedge clock);
    reset_n   = 1'b1;
    exp_rdata = '0;
    v = '{1'b1, 1'b1, 32'h8, 64'hA0A0, 1'b1, 1'b1, 32'h10, 64'hB1B1, 1'b0};
    drive(v);
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      chk($sformatf("rr%0d.r0_gnt", k), 64'(bus.r0_gnt), 64'(k % 2 == 0));
      chk($sformatf("rr%0d.r1_gnt", k), 64'(bus.r1_gnt), 64'(k % 2 == 1));
      chk($sformatf("rr%0d.mem_addr", k), 64'(bus.mem_addr), (k % 2 == 0) ? 64'h8 : 64'h10);
      @(posedge clock); #1;
      chk($sformatf("rr%0d.busy", k), 64'(bus.busy), 64'd0);
    end
    idle_inputs();
    ref_mem[1] = 64'hA0A0;
    ref_mem[2] = 64'hB1B1;
    m_ptr = 1'b0;

    tbl[0] = '{1'b1, 1'b0, 32'h100, 64'h0,    1'b0, 1'b0, 32'h0,   64'h0,    1'b0};
    tbl[1] = '{1'b0, 1'b0, 32'h0,   64'h0,    1'b1, 1'b1, 32'h40,  64'h55AA, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 32'h40,  64'h0,    1'b1, 1'b1, 32'h48,  64'h1234, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 32'h10,  64'hAAAA, 1'b1, 1'b0, 32'h48,  64'h0,    1'b1};
    tbl[4] = '{1'b0, 1'b0, 32'h0,   64'h0,    1'b1, 1'b0, 32'h100, 64'h0,    1'b1};
    tbl[5] = '{1'b0, 1'b1, 32'h18,  64'h77,   1'b0, 1'b1, 32'h20,  64'h88,   1'b0};
    tbl[6] = '{1'b1, 1'b0, 32'h100, 64'h0,    1'b0, 1'b0, 32'h0,   64'h0,    1'b0};
    tbl[7] = '{1'b1, 1'b0, 32'h108, 64'h0,    1'b0, 1'b0, 32'h0,   64'h0,    1'b0};
    tbl[8] = '{1'b1, 1'b0, 32'h110, 64'h0,    1'b0, 1'b0, 32'h0,   64'h0,    1'b0};
    for (int i = 0; i < 9; i++) run_access(tbl[i], $sformatf("vec%0d", i));

    // Reset during WAIT: access abandoned, pointer back to r0.
    @(negedge clock);
    v = '{1'b1, 1'b0, 32'h100, 64'h0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0};
    drive(v);
    @(posedge clock); #1;
    chk("rstmid.r0_gnt", 64'(bus.r0_gnt), 64'd1);
    @(posedge clock); #1;
    chk("rstmid.busy_wait", 64'(bus.busy), 64'd1);
    @(negedge clock);
    reset_n = 1'b0;
    v = '{1'b1, 1'b0, 32'h100, 64'h0, 1'b1, 1'b0, 32'h108, 64'h0, 1'b0};
    drive(v);
    @(posedge clock); #1;
    chk_all_zero("rstmid");
    @(posedge clock); #1;
    chk_all_zero("rsthold");
    reset_n   = 1'b1;
    idle_inputs();
    exp_rdata = '0;
    m_ptr     = 1'b0;
    run_access(v, "post_rst");

    for (int i = 0; i < 40; i++) begin
      v = rand_vec();
      run_access(v, $sformatf("rnd%0d", i));
    end

    @(negedge clock);
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port data/instruction memory between two requesters: requester 0 is the multicycle RISC-V CPU datapath memory port, and requester 1 is a loader/debug port.
- Serialises accesses with a round-robin, one-access-at-a-time FSM.
- Supports fixed memory read latency, registered grants and a single-cycle read-data valid strobe.
- Sits between the datapath's IorD-muxed address path and the memory array.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 64, data width (RV64 ld/sd doubleword).
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata. Legal range 1..7.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- r0_req  in  1  requester 0 access request.
- r0_we  in  1  requester 0 write (1) / read (0).
- r0_addr  in  ADDR_W  requester 0 address.
- r0_wdata  in  DATA_W  requester 0 write data.
- r0_gnt  out  1  requester 0 access issued (one-cycle pulse).
- r0_rvalid  out  1  requester 0 read data valid (one-cycle pulse).
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid  as for requester 0.
- rdata  out  DATA_W  read data, shared by both requesters. Qualified by rX_rvalid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state goes to IDLE.
  - Priority pointer is set to requester 0.
  - Latched request is cleared and the latency counter is cleared to 0.
  - All outputs are 0, including rdata.
  - Reset mid-access abandons the access; no rvalid is ever produced for it.
- FSM states: IDLE, ACCESS, WAIT.
- IDLE:
  - If any rX_req=1, select the winner by the round-robin pointer.
  - If both request, the pointer's favourite wins. If only one requests, it wins regardless of the pointer.
  - Latch winner ID, we, addr and wdata, then go to ACCESS.
  - Flip the pointer to favour the loser (the non-winner ID).
  - If no request, stay in IDLE.
- ACCESS (exactly one cycle):
  - Assert rX_gnt for the latched winner only.
  - Assert mem_en=1, with mem_we, mem_addr and mem_wdata driven from the latched values.
  - Write: next state is IDLE.
  - Read: next state is WAIT with the counter loaded to MEM_LAT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 1, assert rX_rvalid for the winner and drive rdata = mem_rdata, registered into the rdata output. Next state is IDLE.
  - mem_en=0 throughout WAIT.
- Timing (IDLE sees req at cycle t):
  - gnt and mem_en at t+1.
  - Read rvalid at t+1+MEM_LAT.
  - IDLE re-entered at t+2 for a write, t+2+MEM_LAT for a read.
  - Peak throughput: one write per 2 cycles, one read per MEM_LAT+2 cycles.
- Requester rules:
  - Hold req, we, addr and wdata stable from assertion through the gnt cycle.
  - req may stay high after gnt to issue a back-to-back access; it is resampled only in IDLE.
  - Input changes while not in IDLE are ignored, because latched values drive the memory.
- Requests arriving while busy=1 wait; no queuing beyond the held req.
- Fairness: with both requesters holding req continuously, grants strictly alternate.
- rdata holds its last value between rvalid pulses; gnt and rvalid are never asserted for both requesters in the same cycle.
- Simultaneous events: the rvalid cycle and a new req in the same cycle are handled in order. The req is sampled in the following IDLE cycle; no overlap of accesses.

Decomposition:
- Package mem_arb_pkg holds:
  - the state encoding (IDLE, ACCESS, WAIT as 2-bit localparams);
  - requester ID constants REQ_CPU=0 and REQ_AUX=1;
  - the counter width constant (3 bits).
- One sub-module, rr_arb2: a combinational 2-way round-robin picker.
  - Inputs: req[1:0], pointer.
  - Outputs: winner ID, any_req.
  - The pointer register stays in the parent.

Test Plan:
- Single read, MEM_LAT=2: r0 reads addr 0x100, memory model returns 0xDEADBEEF_00000001 → r0_gnt and mem_en at t+1 with mem_addr=0x100 and mem_we=0; r0_rvalid at t+3 with rdata=0xDEADBEEF_00000001; busy low at t+4; r1 signals silent.
- Single write: r1 writes 0x55AA to addr 0x40 → mem_en=1, mem_we=1, mem_addr=0x40, mem_wdata=0x55AA at t+1, r1_gnt pulse; no rvalid; IDLE at t+2.
- Contention: both request from reset, held high for 4 accesses → grant order r0, r1, r0, r1; no cycle with both gnt asserted.
- Back-to-back reads from r0 only, 3 accesses → gnt pulses spaced MEM_LAT+2=4 cycles apart; each rvalid exactly 2 cycles after its gnt.
- Reset mid-read: reset_n=0 in the WAIT cycle after gnt → all outputs 0 next cycle; no rvalid afterwards; first request after release is granted to r0 when both request.
- Input wiggle: r0_addr changes from 0x100 to 0x200 during WAIT → read completes with data for 0x100; mem_addr stays 0x100 in the ACCESS cycle.
